// File: rtl/core_muldiv_pkg.sv
// rtl/core_muldiv_pkg.sv - shared types and constants for the M-extension multiply/divide unit
package core_muldiv_pkg;

  localparam logic [6:0] M_FUNCT7 = 7'b0000001;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/core_muldiv_step.sv
// rtl/core_muldiv_step.sv - one radix-2 iteration: shift-add multiply or restoring divide
// hi/lo hold {partial product high, multiplier} for multiply, {remainder, dividend/quotient} for divide.
module core_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            i_is_div,
  input  logic [XLEN:0]   i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_opb,
  output logic [XLEN:0]   o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_trial;
  logic          w_qbit;

  always_comb begin
    w_sum   = {1'b0, i_hi[XLEN-1:0]} + (i_lo[0] ? {1'b0, i_opb} : '0);
    w_shift = {i_hi[XLEN-1:0], i_lo[XLEN-1]};
    w_trial = w_shift - {1'b0, i_opb};
    // The remainder is always below the divisor, so bit XLEN of the trial is its sign.
    w_qbit  = ~w_trial[XLEN];
    if (i_is_div) begin
      o_hi = w_qbit ? w_trial : w_shift;
      o_lo = {i_lo[XLEN-2:0], w_qbit};
    end else begin
      o_hi = {1'b0, w_sum[XLEN:1]};
      o_lo = {w_sum[0], i_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/core_muldiv.sv
// rtl/core_muldiv.sv - iterative RV32M/RV64M multiply/divide unit with start/ready/valid handshake
// Define CORE_MULDIV_FAST_MUL_EN for a single-cycle registered multiplier on MUL/MULH*.
module core_muldiv
  import core_muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_num1u,
  input  logic [XLEN-1:0] i_num2u,
  input  logic            i_flush,
  output logic            o_ready,
  output logic            o_valid,
  output logic [XLEN-1:0] o_res
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e          r_state;
  funct3_e         r_funct3;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN:0]   r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_opb;
  logic            r_neg;
  logic            r_fast;
  logic            r_valid;
  logic [XLEN-1:0] r_res;

  funct3_e         w_f3;
  logic            w_sgn1, w_sgn2, w_neg1, w_neg2, w_div, w_rem;
  logic            w_div0, w_ovf;
  logic [XLEN-1:0] w_mag1, w_mag2, w_fast_res;
  logic [XLEN:0]   w_hi_nxt;
  logic [XLEN-1:0] w_lo_nxt;
  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0] w_done_res;
`ifdef CORE_MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_prod;
  assign w_fast_prod = (2*XLEN)'(w_mag1) * (2*XLEN)'(w_mag2);
`endif

  // Accept-side decode: magnitudes, result sign and the divide special cases.
  always_comb begin
    w_f3       = funct3_e'(i_funct3);
    w_sgn1     = (w_f3 == F3_MULH) || (w_f3 == F3_MULHSU) || (w_f3 == F3_DIV) || (w_f3 == F3_REM);
    w_sgn2     = (w_f3 == F3_MULH) || (w_f3 == F3_DIV) || (w_f3 == F3_REM);
    w_neg1     = w_sgn1 & i_num1u[XLEN-1];
    w_neg2     = w_sgn2 & i_num2u[XLEN-1];
    w_mag1     = w_neg1 ? (XLEN'(0) - i_num1u) : i_num1u;
    w_mag2     = w_neg2 ? (XLEN'(0) - i_num2u) : i_num2u;
    w_div      = i_funct3[2];
    w_rem      = i_funct3[1];
    w_div0     = w_div && (i_num2u == '0);
    w_ovf      = w_div && w_sgn2 && (i_num1u == MOST_NEG) && (i_num2u == '1);
    w_fast_res = w_div0 ? (w_rem ? i_num1u : '1) : (w_rem ? '0 : i_num1u);
  end

  core_muldiv_step #(.XLEN(XLEN)) u_step (
    .i_is_div (r_funct3[2]),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .i_opb    (r_opb),
    .o_hi     (w_hi_nxt),
    .o_lo     (w_lo_nxt)
  );

  always_comb begin
    w_prod   = {r_hi[XLEN-1:0], r_lo};
    w_prod_s = r_neg ? ((2*XLEN)'(0) - w_prod) : w_prod;
    case (r_funct3)
      F3_MUL:                      w_done_res = w_prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_done_res = w_prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:             w_done_res = r_neg ? (XLEN'(0) - r_lo) : r_lo;
      default:                     w_done_res = r_neg ? (XLEN'(0) - r_hi[XLEN-1:0]) : r_hi[XLEN-1:0];
    endcase
    if (r_fast) w_done_res = r_lo;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_funct3 <= F3_MUL;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opb    <= '0;
      r_neg    <= 1'b0;
      r_fast   <= 1'b0;
      r_valid  <= 1'b0;
      r_res    <= '0;
    end else if (i_flush) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_funct3 <= w_f3;
            r_cnt    <= '0;
            r_neg    <= (w_div && w_rem) ? w_neg1 : (w_neg1 ^ w_neg2);
            r_hi     <= '0;
            r_lo     <= w_div ? w_mag1 : w_mag2;
            r_opb    <= w_div ? w_mag2 : w_mag1;
            r_fast   <= 1'b0;
            r_state  <= ST_CALC;
            if (w_div0 || w_ovf) begin
              r_lo    <= w_fast_res;
              r_fast  <= 1'b1;
              r_state <= ST_DONE;
            end
`ifdef CORE_MULDIV_FAST_MUL_EN
            if (!w_div) begin
              {r_hi, r_lo} <= {1'b0, w_fast_prod};
              r_state      <= ST_DONE;
            end
`endif
          end
        end
        ST_CALC: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_valid <= 1'b1;
          r_res   <= w_done_res;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ready = (r_state == ST_IDLE);
  assign o_valid = r_valid;
  assign o_res   = r_res;

endmodule

// File: doc/core_muldiv.md
Name: core_muldiv

Overview:
Iterative RV32M/RV64M multiply-divide unit; the sequential companion to the single-cycle integer ALU in the execute stage.
- Handles all eight OP funct7=0000001 operations: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Radix-2 shift-add multiply and restoring divide, one bit per cycle.
- Start/busy/valid handshake so the pipeline stalls while the unit is busy.

Parameters:
XLEN, 32, operand/result width (32 or 64)
CNT_W, $clog2(XLEN)+1, iteration counter width (derived, do not override)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
i_start  in  1  request; accepted only when o_ready=1
i_funct3  in  3  M-extension funct3 (000 MUL … 111 REMU)
i_num1u  in  XLEN  rs1 value
i_num2u  in  XLEN  rs2 value
i_flush  in  1  pipeline flush; aborts any operation in progress
o_ready  out  1  unit idle, can accept i_start
o_valid  out  1  one-cycle pulse: o_res valid
o_res  out  XLEN  result; held until next accepted start

Behaviour:
- Reset (async, rst=1): state=IDLE, o_ready=1, o_valid=0, o_res=0, counter=0, all datapath registers=0.
- States and transitions:
  - IDLE: o_ready=1. On i_start & !i_flush, latch funct3 and operands. Go to CALC, or to DONE if the fast path applies.
  - CALC: o_ready=0. Performs one step per cycle and increments the counter. After XLEN steps, go to DONE.
  - DONE: o_valid=1 and o_res updated for exactly one cycle, then IDLE. o_ready=0 in DONE.
- Latency, normal path: with start accepted at edge N, o_valid is high in the cycle after edge N+XLEN+1. For XLEN=32 that is 33 cycles.
- Fast path: start to o_valid in 1 cycle, no CALC.
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give the dividend.
  - Signed overflow (DIV/REM with rs1=most-negative, rs2=-1): DIV gives rs1; REM gives 0.
- Sign handling:
  - Signed operands are converted to magnitudes on accept; the result sign is fixed in the DONE transition.
  - MULH: both operands signed. MULHSU: rs1 signed, rs2 unsigned. MULHU/DIVU/REMU: both unsigned.
  - DIV sign = sign1^sign2. REM sign = sign of dividend (RISC-V truncating division).
- Widths:
  - Multiply accumulates a 2*XLEN product. MUL returns the low XLEN bits; MULH* return the high XLEN bits, after two's-complement negation of the full 2*XLEN value when the result is negative.
  - Divide uses an XLEN+1-bit partial remainder; a quotient bit is set when the trial subtraction is non-negative.
- i_start while o_ready=0: ignored, no state change.
- i_flush in any state: next state is IDLE, o_valid stays 0, o_res unchanged. Flush has priority over a simultaneous i_start, which is not accepted.
- Reset asserted mid-operation: immediate return to reset values; no o_valid.
- Undefined funct3 cannot occur (all 8 are legal).

Optional Feature:
Macro: CORE_MULDIV_FAST_MUL_EN
- Defined: MUL/MULH/MULHSU/MULHU use one combinational XLEN×XLEN multiplier, registered. They go IDLE→DONE, so o_valid comes 1 cycle after accept. Divides are unchanged.
- Undefined: all multiplies are iterative (XLEN+1 latency), with no hardware multiplier inferred.

Decomposition:
- Package core_muldiv_pkg:
  - enum of the M funct3 codes (MUL…REMU)
  - state enum (IDLE, CALC, DONE)
  - localparam for the M-extension funct7 (7'b0000001)
- Sub-module core_muldiv_step: combinational one-iteration datapath (shift-add or restore-subtract, selected by an is_div input), parametrised by XLEN. The top level holds the FSM, counter, sign fix-up and fast path.

Test Plan:
1. MUL 7 × 0xFFFFFFFD (−3) → o_res=0xFFFFFFEB, o_valid exactly 33 cycles after accept; o_ready low throughout.
2. MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
3. DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
4. DIVU 0x1234/0 → 0xFFFFFFFF. REM 0x1234/0 → 0x1234. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM same → 0. Each gives o_valid 1 cycle after accept.
5. Flush at cycle 10 of a DIV → IDLE next cycle, no o_valid, o_res keeps its previous value. i_start+i_flush together → not accepted. i_start while busy → ignored, original result still correct.
6. Async rst pulse mid-CALC (between clock edges) → o_ready=1, o_valid=0, o_res=0 immediately. With CORE_MULDIV_FAST_MUL_EN defined, rerun scenario 1 → same result with 1-cycle latency.
